// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle for fetch_decode_buffer.
// The slave modport is the buffer's view; the master modport drives fetch and decode.
interface fetch_decode_buffer_if #(
   parameter int VADDR_WIDTH      = 32,
   parameter int MAX_ILEN         = 32,
   parameter int XCPT_CAUSE_WIDTH = 32,
   parameter int DEPTH            = 4
);
   logic                          flush_i;
   logic                          fetch_valid_i;
   logic                          fetch_ready_o;
   logic [VADDR_WIDTH-1:0]        fetch_pc_i;
   logic [MAX_ILEN-1:0]           fetch_instr_i;
   logic                          fetch_bp_is_branch_i;
   logic                          fetch_bp_taken_i;
   logic [VADDR_WIDTH-1:0]        fetch_bp_pred_addr_i;
   logic                          fetch_xcpt_valid_i;
   logic [XCPT_CAUSE_WIDTH-1:0]   fetch_xcpt_cause_i;
   logic                          instr_valid_o;
   logic                          deco_ready_i;
   logic [VADDR_WIDTH-1:0]        instr_pc_o;
   logic [MAX_ILEN-1:0]           instr_content_o;
   logic                          bp_is_branch_o;
   logic                          bp_decision_o;
   logic [VADDR_WIDTH-1:0]        bp_pred_addr_o;
   logic                          xcpt_valid_o;
   logic [VADDR_WIDTH-1:0]        xcpt_origin_o;
   logic [XCPT_CAUSE_WIDTH-1:0]   xcpt_cause_o;
   logic [$clog2(DEPTH+1)-1:0]    count_o;

   modport slave (
      input  flush_i, fetch_valid_i, fetch_pc_i, fetch_instr_i,
             fetch_bp_is_branch_i, fetch_bp_taken_i, fetch_bp_pred_addr_i,
             fetch_xcpt_valid_i, fetch_xcpt_cause_i, deco_ready_i,
      output fetch_ready_o, instr_valid_o, instr_pc_o, instr_content_o,
             bp_is_branch_o, bp_decision_o, bp_pred_addr_o,
             xcpt_valid_o, xcpt_origin_o, xcpt_cause_o, count_o
   );

   modport master (
      output flush_i, fetch_valid_i, fetch_pc_i, fetch_instr_i,
             fetch_bp_is_branch_i, fetch_bp_taken_i, fetch_bp_pred_addr_i,
             fetch_xcpt_valid_i, fetch_xcpt_cause_i, deco_ready_i,
      input  fetch_ready_o, instr_valid_o, instr_pc_o, instr_content_o,
             bp_is_branch_o, bp_decision_o, bp_pred_addr_o,
             xcpt_valid_o, xcpt_origin_o, xcpt_cause_o, count_o
   );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode FIFO with exception hold state and flush.
// Define FETCH_DECODE_BUFFER_BYPASS_EN to forward fetch data straight to decode when empty.
module fetch_decode_buffer #(
   parameter int VADDR_WIDTH      = 32,
   parameter int MAX_ILEN         = 32,
   parameter int XCPT_CAUSE_WIDTH = 32,
   parameter int DEPTH            = 4
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   fetch_decode_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [VADDR_WIDTH-1:0]      pc;
      logic [MAX_ILEN-1:0]         instr;
      logic                        is_branch;
      logic                        taken;
      logic [VADDR_WIDTH-1:0]      pred;
      logic                        xv;
      logic [XCPT_CAUSE_WIDTH-1:0] cause;
   } entry_t;

   typedef enum logic {RUN, XCPT_HOLD} state_t;

   state_t           r_state;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   entry_t           r_mem [DEPTH];

   entry_t w_in, w_head, w_out, w_data;
   logic   w_empty, w_ready, w_valid, w_push, w_pop, w_wr, w_rd;

   always_comb begin
      w_in           = '0;
      w_in.pc        = bus.fetch_pc_i;
      w_in.instr     = bus.fetch_instr_i;
      w_in.is_branch = bus.fetch_bp_is_branch_i;
      w_in.taken     = bus.fetch_bp_taken_i;
      w_in.pred      = bus.fetch_bp_pred_addr_i;
      w_in.xv        = bus.fetch_xcpt_valid_i;
      w_in.cause     = bus.fetch_xcpt_cause_i;
   end

   assign w_empty = (r_count == '0);
   // rstn_i gates ready so nothing is accepted while reset is held
   assign w_ready = rstn_i && (r_state == RUN) && (r_count < CNT_W'(DEPTH)) && !bus.flush_i;
   assign w_push  = bus.fetch_valid_i && w_ready;
   assign w_head  = r_mem[r_rd_ptr];
   assign w_pop   = w_valid && bus.deco_ready_i;

`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
   // Empty buffer: present the fetch beat directly; store it only if decode does not take it
   assign w_valid = !bus.flush_i && (!w_empty || w_push);
   assign w_out   = w_empty ? w_in : w_head;
   assign w_wr    = w_push && !(w_empty && w_pop);
   assign w_rd    = w_pop && !w_empty;
`else
   assign w_valid = !w_empty && !bus.flush_i;
   assign w_out   = w_head;
   assign w_wr    = w_push;
   assign w_rd    = w_pop;
`endif

   assign w_data = w_valid ? w_out : '0;

   assign bus.fetch_ready_o   = w_ready;
   assign bus.instr_valid_o   = w_valid;
   assign bus.instr_pc_o      = w_data.pc;
   assign bus.instr_content_o = w_data.instr;
   assign bus.bp_is_branch_o  = w_data.is_branch;
   assign bus.bp_decision_o   = w_data.taken;
   assign bus.bp_pred_addr_o  = w_data.pred;
   assign bus.xcpt_valid_o    = w_data.xv;
   assign bus.xcpt_origin_o   = w_data.pc;
   assign bus.xcpt_cause_o    = w_data.cause;
   assign bus.count_o         = r_count;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= RUN;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush_i) begin
         r_state  <= RUN;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
         if (r_state == RUN && w_push && bus.fetch_xcpt_valid_i)
            r_state <= XCPT_HOLD;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_in;
   end
endmodule
